// File: rtl/gol_sequencer.sv
// -----------------------------------------------------------------------------
// gol_sequencer
//
// Control block for a serial-chain Game of Life grid of N cells. Loads the
// initial pattern bit-serially, then repeatedly steps the grid one generation,
// streams the new generation out under ready/valid backpressure and decides
// whether to stop (extinction, still life, or generation target reached).
//
// Ports:
//   i_clock        sole clock, rising edge
//   i_reset        asynchronous active-high reset, clears all state
//   i_abort        synchronous return to IDLE, clears counters and flags
//   i_bit_in       serial pattern bit (consumed by the grid head mux)
//   i_bit_valid    i_bit_in qualifier, honoured in IDLE only
//   i_start        begin (IDLE, fully loaded) or restart (DONE) a run
//   i_gen_target   generations to run, 0 = until extinct/stable
//   i_out_ready    downstream accepts o_out_bit
//   i_grid_tail    last cell of the grid chain
//   o_shift_en     advance the grid chain one position
//   o_shift_src    chain head source: 0 = bit_in, 1 = recirculate tail
//   o_update       one-cycle pulse, grid latches next generation
//   o_out_bit      current tail bit being streamed
//   o_out_valid    o_out_bit valid
//   o_gen_count    generations computed this run (saturating)
//   o_state        IDLE=0, UPDATE=1, DUMP=2, CHECK=3, DONE=4
//   o_done, o_extinct, o_stable   run-termination flags
// -----------------------------------------------------------------------------
module gol_sequencer #(
  parameter int N     = 25,
  parameter int GEN_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_abort,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  input  logic             i_start,
  input  logic [GEN_W-1:0] i_gen_target,
  input  logic             i_out_ready,
  input  logic             i_grid_tail,
  output logic             o_shift_en,
  output logic             o_shift_src,
  output logic             o_update,
  output logic             o_out_bit,
  output logic             o_out_valid,
  output logic [GEN_W-1:0] o_gen_count,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic             o_extinct,
  output logic             o_stable
);

  localparam int             CNT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UPDATE = 3'd1,
    S_DUMP   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_load_cnt;
  logic [CNT_W-1:0]   r_dump_cnt;
  logic [GEN_W-1:0]   r_gen_count;
  logic [N-1:0]       r_shadow;
  logic               r_shadow_valid;
  logic               r_alive;
  logic               r_mismatch;
  logic               r_extinct;
  logic               r_stable;
  logic               w_accept;

  // The serial bit goes straight from the board to the grid head mux; the
  // sequencer only qualifies it through shift_en/shift_src.
  logic w_unused_bit_in;
  assign w_unused_bit_in = i_bit_in;

  // A beat is accepted only when it is genuinely offered (not masked by
  // abort/reset) and taken by the downstream.
  assign w_accept = o_out_valid & i_out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and combinational grid controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_shift_en   = 1'b0;
    o_shift_src  = 1'b0;
    o_update     = 1'b0;
    o_out_valid  = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_shift_en = i_bit_valid;
        if (i_start && (r_load_cnt == N_CNT)) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        o_update     = 1'b1;
        w_state_next = S_DUMP;
      end
      S_DUMP: begin
        o_out_valid = 1'b1;
        o_shift_src = 1'b1;
        o_shift_en  = i_out_ready;
        if (i_out_ready && (r_dump_cnt == LAST_BEAT)) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!r_alive) begin
          w_state_next = S_DONE;
        end else if (r_shadow_valid && !r_mismatch) begin
          w_state_next = S_DONE;
        end else if ((i_gen_target != '0) && (r_gen_count == i_gen_target)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_UPDATE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_state_next = S_UPDATE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort freezes the chain and withdraws the current beat so that a beat
    // the downstream sees as accepted is always one the chain has advanced on.
    if (i_abort) begin
      w_state_next = S_IDLE;
      o_shift_en   = 1'b0;
      o_out_valid  = 1'b0;
    end

    // Grid controls are forced quiet for as long as reset is held.
    if (i_reset) begin
      o_shift_en  = 1'b0;
      o_update    = 1'b0;
      o_out_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, shadow copy and termination flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_load_cnt     <= '0;
      r_dump_cnt     <= '0;
      r_gen_count    <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_alive        <= 1'b0;
      r_mismatch     <= 1'b0;
      r_extinct      <= 1'b0;
      r_stable       <= 1'b0;
    end else if (i_abort) begin
      r_load_cnt     <= '0;
      r_dump_cnt     <= '0;
      r_gen_count    <= '0;
      r_shadow_valid <= 1'b0;
      r_alive        <= 1'b0;
      r_mismatch     <= 1'b0;
      r_extinct      <= 1'b0;
      r_stable       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_bit_valid && (r_load_cnt != N_CNT)) begin
            r_load_cnt <= r_load_cnt + CNT_W'(1);
          end
        end
        S_UPDATE: begin
          if (r_gen_count != '1) begin
            r_gen_count <= r_gen_count + GEN_W'(1);
          end
          r_dump_cnt <= '0;
          r_alive    <= 1'b0;
          r_mismatch <= 1'b0;
        end
        S_DUMP: begin
          if (w_accept) begin
            r_alive    <= r_alive | i_grid_tail;
            // The shadow holds the previous dump in beat order, so the bit
            // falling out of it is the same cell one generation earlier.
            r_shadow   <= {r_shadow[N-2:0], i_grid_tail};
            r_mismatch <= r_mismatch | (i_grid_tail != r_shadow[N-1]);
            r_dump_cnt <= r_dump_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_shadow_valid <= 1'b1;
          if (!r_alive) begin
            r_extinct <= 1'b1;
          end else if (r_shadow_valid && !r_mismatch) begin
            r_stable <= 1'b1;
          end
        end
        S_DONE: begin
          // Restart keeps the grid contents but begins a fresh comparison
          // history, so the first new generation can never read as stable.
          if (i_start) begin
            r_gen_count    <= '0;
            r_extinct      <= 1'b0;
            r_stable       <= 1'b0;
            r_shadow_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_out_bit   = i_grid_tail;
  assign o_gen_count = r_gen_count;
  assign o_state     = r_state;
  assign o_done      = (r_state == S_DONE);
  assign o_extinct   = r_extinct;
  assign o_stable    = r_stable;

endmodule
